// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the boot loader and its byte packer.
// Defaults describe the 64 x 32-bit program memory read by the fetch stage.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int DEPTH          = 64;
    localparam int AW             = 6;
    localparam int BYTES_PER_WORD = WORD_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DONE,
        ERR
    } state_t;

    // Byte-lane index width; a one-byte word still needs a 1-bit counter.
    function automatic int idx_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into N-bit words.
// o_word_valid pulses combinationally with the last byte so the word can be written on that same edge.
module byte_packer #(
    parameter int N = imem_loader_pkg::WORD_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic [7:0]   i_byte_in,
    input  logic         i_load,
    output logic [N-1:0] o_word,
    output logic         o_word_valid
);
    import imem_loader_pkg::*;

    localparam int BPW = N / 8;
    localparam int IW  = idx_width(BPW);

    logic [IW-1:0] r_idx;
    logic          w_last;

    assign w_last       = (r_idx == IW'(BPW - 1));
    assign o_word_valid = i_load && w_last;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx <= '0;
        end else if (i_clear) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // The lane currently being loaded is taken straight from the input, so the
    // full word is already assembled during the final byte's cycle.
    for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
        logic [7:0] r_lane;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_lane <= '0;
            end else if (i_clear) begin
                r_lane <= '0;
            end else if (i_load && (r_idx == IW'(gi))) begin
                r_lane <= i_byte_in;
            end
        end

        assign o_word[8*gi +: 8] = (r_idx == IW'(gi)) ? i_byte_in : r_lane;
    end

endmodule

// File: rtl/imem_loader.sv
// Writable program memory with a byte-stream boot loader; holds the CPU in reset
// until a load of <len> words completes. Read port is combinational like the instruction ROM.
module imem_loader #(
    parameter int N     = imem_loader_pkg::WORD_W,
    parameter int DEPTH = imem_loader_pkg::DEPTH,
    parameter int AW    = imem_loader_pkg::AW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [7:0]    i_byte_in,
    input  logic          i_byte_valid,
    output logic          o_byte_ready,
    input  logic [AW-1:0] i_addr,
    output logic [N-1:0]  o_q,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_hold_cpu,
    output logic [AW:0]   o_word_count
);
    import imem_loader_pkg::*;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_word_count;
    logic [7:0]    r_len;

    logic          w_xfer;
    logic          w_start_ok;
    logic          w_hdr_bad;
    logic          w_load;
    logic [N-1:0]  w_word;
    logic          w_word_valid;
    logic [AW:0]   w_wc_inc;
    logic          w_last_word;

    // Contents survive reset; only the power-up image is zero.
    logic [N-1:0]  r_mem [DEPTH] = '{default: '0};

    assign w_xfer      = o_byte_ready && i_byte_valid;
    assign w_start_ok  = i_start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_hdr_bad   = (i_byte_in == 8'd0) || (int'(i_byte_in) > DEPTH);
    assign w_load      = w_xfer && (r_state == DATA);
    assign w_wc_inc    = r_word_count + 1'b1;
    assign w_last_word = w_word_valid && (int'(w_wc_inc) == int'(r_len));

    byte_packer #(
        .N (N)
    ) u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_start_ok),
        .i_byte_in    (i_byte_in),
        .i_load       (w_load),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    w_state_next = HDR;
                end
            end
            HDR: begin
                if (w_xfer) begin
                    w_state_next = w_hdr_bad ? ERR : DATA;
                end
            end
            DATA: begin
                if (w_last_word) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_hold_cpu   = 1'b1;
        case (r_state)
            HDR, DATA: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
            DONE: begin
                o_done     = 1'b1;
                o_hold_cpu = 1'b0;
            end
            ERR: begin
                o_err = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr        <= '0;
            r_word_count <= '0;
            r_len        <= '0;
        end else if (w_start_ok) begin
            r_ptr        <= '0;
            r_word_count <= '0;
        end else if ((r_state == HDR) && w_xfer) begin
            r_len <= i_byte_in;
        end else if (w_word_valid) begin
            r_word_count <= w_wc_inc;
            // Saturate so a full-depth load leaves the pointer on the last word.
            if (r_ptr != AW'(DEPTH - 1)) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_word_valid) begin
            r_mem[r_ptr] <= w_word;
        end
    end

    assign o_q          = r_mem[i_addr];
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: completion events are checked by a scoreboard monitor,
// memory contents and handshake timing by directed reads.
module tb_imem_loader;
    localparam int N     = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic [7:0]    byte_in    = 8'h00;
    logic          byte_valid = 1'b0;
    logic [AW-1:0] addr       = '0;
    logic          byte_ready;
    logic [N-1:0]  q;
    logic          busy;
    logic          done;
    logic          err;
    logic          hold_cpu;
    logic [AW:0]   word_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit is_err;
        int wc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    imem_loader #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_byte_in    (byte_in),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .i_addr       (addr),
        .o_q          (q),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_hold_cpu   (hold_cpu),
        .o_word_count (word_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_load(input bit is_err, input int wc);
        exp_t e;
        e.is_err = is_err;
        e.wc     = wc;
        exp_q.push_back(e);
    endtask

    task automatic chk_mem(input int a, input logic [31:0] exp);
        addr = AW'(a);
        #1;
        check($sformatf("mem[%0d]", a), q, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_byte: byte_ready=%0b after %0d cycles, required 1", byte_ready, t);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[8*b +: 8], $urandom_range(0, gapmax));
        end
    endtask

    // Scoreboard monitor: every rising done/err is one completed load.
    initial begin : monitor
        logic prev_done = 1'b0;
        logic prev_err  = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ((done && !prev_done) || (err && !prev_err))) begin
                $display("load complete: done=%0b err=%0b word_count=%0d hold_cpu=%0b",
                         done, err, word_count, hold_cpu);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_completion: done=%0b err=%0b, required no completion", done, err);
                end else begin
                    e = exp_q.pop_front();
                    check("completion_done", done, !e.is_err);
                    check("completion_err", err, e.is_err);
                    check("completion_word_count", word_count, e.wc);
                    check("completion_hold_cpu", hold_cpu, e.is_err);
                end
            end
            prev_done = done;
            prev_err  = err;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] w;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_hold_cpu", hold_cpu, 1);
        check("rst_word_count", word_count, 0);
        chk_mem(0, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;

        // start together with reset: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start_with_reset_busy", busy, 0);

        // Basic two-word load, byte_valid held high
        expect_load(0, 2);
        pulse_start();
        check("hdr_busy", busy, 1);
        send_byte(8'h02, 0);
        send_word(32'hf800_0001, 0);
        send_word(32'hf800_8002, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("basic_done", done, 1);
        check("basic_hold_cpu", hold_cpu, 0);
        check("basic_word_count", word_count, 2);
        check("basic_byte_ready", byte_ready, 0);
        chk_mem(0, 32'hf800_0001);
        chk_mem(1, 32'hf800_8002);
        chk_mem(2, 32'h0000_0000);

        // Bad header 0
        expect_load(1, 0);
        pulse_start();
        send_byte(8'h00, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("hdr0_err", err, 1);
        check("hdr0_hold_cpu", hold_cpu, 1);
        check("hdr0_byte_ready", byte_ready, 0);
        chk_mem(0, 32'hf800_0001);

        // Bad header 65
        expect_load(1, 0);
        pulse_start();
        send_byte(8'h41, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("hdr65_err", err, 1);

        // Recovery after error
        expect_load(0, 1);
        pulse_start();
        send_byte(8'h01, 0);
        send_word(32'hb400_001f, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("recover_done", done, 1);
        check("recover_err", err, 0);
        chk_mem(0, 32'hb400_001f);
        chk_mem(1, 32'hf800_8002);

        // Full-depth load with gaps, a stray start, and a read during write
        expect_load(0, 64);
        pulse_start();
        send_byte(8'h40, 1);
        for (int k = 0; k < 64; k++) begin
            w = 32'hcafe_0000 + 32'(k);
            if (k == 5) begin
                send_byte(w[7:0], 1);
                send_byte(w[15:8], 1);
                send_byte(w[23:16], 1);
                @(negedge clk);
                addr       = 6'd5;
                byte_in    = w[31:24];
                byte_valid = 1'b1;
                #1;
                check("rdw_ready", byte_ready, 1);
                check("rdw_before_edge", q, 32'h0000_0000);
                @(posedge clk);
                #1;
                check("rdw_after_edge", q, w);
            end else begin
                send_word(w, 2);
            end
            if (k == 10) begin
                @(negedge clk);
                byte_valid = 1'b0;
                start      = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("stray_start_busy", busy, 1);
                check("stray_start_ready", byte_ready, 1);
                check("stray_start_word_count", word_count, 11);
            end
        end
        @(negedge clk);
        check("full_done", done, 1);
        check("full_word_count", word_count, 64);
        check("full_byte_ready", byte_ready, 0);
        byte_in = 8'h55;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        check("done_ignores_bytes_wc", word_count, 64);
        check("done_ignores_bytes_done", done, 1);
        chk_mem(0, 32'hcafe_0000);
        chk_mem(31, 32'hcafe_001f);
        chk_mem(63, 32'hcafe_003f);

        // Preload three words, then reset partway through a reload
        expect_load(0, 3);
        pulse_start();
        send_byte(8'h03, 0);
        repeat (3) send_word(32'h1111_1111, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        pulse_start();
        send_byte(8'h03, 0);
        send_word(32'h1234_5678, 0);
        send_byte(8'haa, 0);
        send_byte(8'hbb, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_byte_ready", byte_ready, 0);
        check("midrst_hold_cpu", hold_cpu, 1);
        check("midrst_done", done, 0);
        check("midrst_word_count", word_count, 0);
        @(negedge clk);
        reset = 1'b0;
        chk_mem(0, 32'h1234_5678);
        chk_mem(1, 32'h1111_1111);
        chk_mem(2, 32'h1111_1111);
        chk_mem(3, 32'hcafe_0003);

        // Full load after the interrupted one
        expect_load(0, 3);
        pulse_start();
        send_byte(8'h03, 0);
        for (int k = 0; k < 3; k++) begin
            send_word(32'hdead_0000 + 32'(k), 1);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        check("reload_done", done, 1);
        chk_mem(0, 32'hdead_0000);
        chk_mem(1, 32'hdead_0001);
        chk_mem(2, 32'hdead_0002);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
